seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter and the transmit end of the serial bit-stream interface consumed by the seq0110 detector.
- Latches a W-bit pattern, a repetition count and an inter-repetition gap on a start pulse.
- Shifts the pattern out MSB-first, one bit per clock, repeating it the requested number of times.
- Used as the stimulus source and loopback partner for serial sequence detectors.

Parameters:
W, 4, pattern width in bits (W >= 2)
CNT_W, 4, width of repetition count
GAP_W, 4, width of inter-repetition gap count
IDLE_BIT, 1'b1, level driven on out when not transmitting

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request; sampled only in IDLE
abort  input  1  synchronous cancel of an in-progress transfer
pattern  input  W  bits to send, MSB first; latched on accepted start
repeat_cnt  input  CNT_W  number of pattern repetitions; latched on accepted start
gap  input  GAP_W  idle cycles between repetitions; latched on accepted start
out  output  1  serial data; connects to detector input in
out_valid  output  1  high on cycles where out carries a pattern bit
busy  output  1  high from the cycle after an accepted start until return to IDLE
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Reset (async, any state): state=IDLE; out=IDLE_BIT; out_valid=0; busy=0; done=0; shift register, bit counter, repetition counter and gap counter all cleared.
- FSM states: IDLE, SHIFT, GAP, FIN.
- IDLE:
  - start=1 and repeat_cnt!=0: latch inputs; go to SHIFT next cycle.
  - First bit appears one cycle after start: out=pattern[W-1], out_valid=1, busy=1.
  - start=1 with repeat_cnt==0: ignored; no busy, no done.
- SHIFT:
  - Emits W bits on consecutive cycles, MSB to LSB; out_valid=1 throughout.
  - After bit 0, if repetitions remain and latched gap!=0: go to GAP.
  - After bit 0, if repetitions remain and latched gap==0: next cycle emits bit W-1 of the next repetition (back-to-back, no bubble).
  - After bit 0 of the last repetition: go to FIN.
- GAP: exactly gap cycles with out=IDLE_BIT and out_valid=0, then SHIFT.
- FIN:
  - One cycle: done=1, busy=1, out=IDLE_BIT, out_valid=0. Then IDLE.
  - busy falls in the cycle after FIN; done is never asserted in any other state.
- Timing: total busy cycles = repeat_cnt*W + (repeat_cnt-1)*gap + 1.
- start while busy: ignored. pattern/repeat_cnt/gap changes while busy: no effect.
- abort=1 in SHIFT, GAP or FIN:
  - Next cycle state=IDLE, out=IDLE_BIT, out_valid=0, busy=0; done not pulsed.
  - abort overrides all other transitions. abort in IDLE has no effect.
- start and abort in the same IDLE cycle: start is ignored.
- Counters are sized to the parameter widths and never wrap during legal operation; the maximum repeat_cnt of 2^CNT_W-1 is supported.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package seq_gen_pkg holds:
  - FSM state encoding constants (IDLE, SHIFT, GAP, FIN; 2-bit).
  - Default IDLE_BIT value.
  - A shared constant for the detector pattern 4'b0110, used by benches.
- One sub-module, seq_piso: W-bit parallel-load, MSB-first shift register with load/shift enables and its own bit-index counter that flags the last bit.
- The FSM, repetition counter and gap counter stay in seq_pattern_gen.

Test Plan:
1. Reset and basic send: reset 2 cycles, then start with pattern=4'b0110, repeat_cnt=1, gap=0. Required: out = 0,1,1,0 on cycles 1-4 after start with out_valid=1; done=1 on cycle 5; busy=0 on cycle 6.
2. Back-to-back repeats: pattern=0110, repeat_cnt=3, gap=0. Required: 12 consecutive valid bits 011001100110; done on cycle 13. Loopback into seq0110 yields exactly 3 seq_detected pulses.
3. Gap between repeats: pattern=0110, repeat_cnt=2, gap=3. Required: 0110; then 3 cycles of out=1 with out_valid=0; then 0110; done on cycle 12.
4. Rejected and ignored starts:
   - repeat_cnt=0 with start: busy stays 0 and no done.
   - A second start mid-transfer (with a different pattern) does not alter the output stream.
5. Abort and reset mid-operation:
   - abort on the 2nd bit of a repeat_cnt=3 transfer: next cycle out=1, out_valid=0, busy=0, no done.
   - Async rst asserted between clock edges mid-SHIFT: outputs return to reset values immediately.
   - After either, a new start transmits normally.
6. Width and maximum count: W=8, pattern=8'hA5, repeat_cnt=15, gap=0. Required: 120 valid bits, each octet 10100101; done on cycle 121.

Source files
------------

// File: rtl/seq_pattern_gen_pkg.sv
// rtl/seq_pattern_gen_pkg.sv - shared constants for the serial pattern generator
// Contents:
//   ST_*              2-bit FSM state encodings
//   IDLE_BIT_DEFAULT  line level when nothing is being transmitted
//   DET_PATTERN       4'b0110, the sequence the paired seq0110 detector looks for
package seq_gen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic       IDLE_BIT_DEFAULT = 1'b1;

  localparam logic [3:0] DET_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - control and serial-output bundle of seq_pattern_gen
// Signals:
//   start, abort, pattern[W], repeat_cnt[CNT_W], gap[GAP_W]  requester -> generator
//   out, out_valid, busy, done                               generator -> requester
// Modports: master (requester side), slave (generator side).
interface seq_pattern_gen_if #(
  parameter int W     = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);

  logic             start;
  logic             abort;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_cnt, gap,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_cnt, gap,
    output out, out_valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_gen_piso.sv
// rtl/seq_pattern_gen_piso.sv - W-bit parallel-in serial-out shift register, MSB first
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_load        load i_data and restart the bit index (wins over i_shift)
//   i_shift       advance to the next lower bit
//   i_data[W]     parallel data to load
//   o_msb         bit currently presented
//   o_last        the presented bit is bit 0 of the loaded word
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb,
  output logic         o_last
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     r_sreg;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[W-2:0], 1'b0};
      r_idx  <= r_idx + IDX_W'(1);
    end
  end

  assign o_msb  = r_sreg[W-1];
  // r_idx counts bits already presented, so W-1 means bit 0 is on the line
  assign o_last = (r_idx == IDX_W'(W - 1));

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - repeating serial pattern transmitter with inter-repetition gap
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   s_if      slave modport: start/abort/pattern/repeat_cnt/gap in,
//             out/out_valid/busy/done out (all outputs driven from flops)
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int   W        = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.slave   s_if
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [W-1:0]     r_pattern;
  logic [CNT_W-1:0] r_rep_left;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_rep_end;
  logic             w_load;
  logic             w_shift;
  logic [W-1:0]     w_load_data;
  logic             w_piso_msb;
  logic             w_piso_last;

  // abort in the same cycle as start keeps the generator idle
  assign w_accept = (r_state == ST_IDLE) && s_if.start && !s_if.abort &&
                    (s_if.repeat_cnt != '0);

  // bit 0 of a repetition that is not the final one
  assign w_rep_end = (r_state == ST_SHIFT) && !s_if.abort && w_piso_last &&
                     (r_rep_left != CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_data = r_pattern;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
          w_load_data = s_if.pattern;
        end
      end
      ST_SHIFT: begin
        if (s_if.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_piso_last) begin
          w_shift = 1'b1;
        end else if (r_rep_left == CNT_W'(1)) begin
          w_state_nxt = ST_FIN;
        end else if (r_gap_len != '0) begin
          w_state_nxt = ST_GAP;
        end else begin
          // back-to-back: reload so the next MSB follows bit 0 with no bubble
          w_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (s_if.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_rep_left  <= '0;
      r_gap_len   <= '0;
      r_gap_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // status flags are registered from the next state so they line up with it
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_SHIFT);
      r_done      <= (w_state_nxt == ST_FIN);
      if (w_accept) begin
        r_pattern  <= s_if.pattern;
        r_rep_left <= s_if.repeat_cnt;
        r_gap_len  <= s_if.gap;
      end
      if (w_rep_end) begin
        r_rep_left <= r_rep_left - CNT_W'(1);
        r_gap_cnt  <= r_gap_len;
      end else if (r_state == ST_GAP) begin
        r_gap_cnt  <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  seq_piso #(
    .W (W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_piso_msb),
    .o_last  (w_piso_last)
  );

  // selection between two flops only; nothing from the inputs reaches out
  assign s_if.out       = r_out_valid ? w_piso_msb : IDLE_BIT;
  assign s_if.out_valid = r_out_valid;
  assign s_if.busy      = r_busy;
  assign s_if.done      = r_done;

endmodule
